// File: rtl/zigbee_pkg.sv
// Shared widths and the packer FSM state type for the ZigBee transmit path.
package zigbee_pkg;

    localparam int SYM_W     = 4;
    localparam int NUM_LANES = 4;
    localparam int WORD_W    = 16;
    localparam int SEL_W     = 2;
    localparam int CNT_W     = 3;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } packer_state_t;

    // Lane 0 is the MSB nibble, so lane k sits 4*k bits below the top of the word.
    function automatic logic [WORD_W-1:0] lane_mask(input logic [SEL_W-1:0] sel);
        return 16'hF000 >> {sel, 2'b00};
    endfunction

endpackage

// File: rtl/demux_sym_packer_if.sv
// Symbol intake and word output handshakes of the symbol-to-word packer.
interface demux_sym_packer_if
    import zigbee_pkg::*;
();

    logic                inSymValid;
    logic [SYM_W-1:0]    inSymData;
    logic                outSymReady;
    logic                inFlush;
    logic                outWordValid;
    logic [WORD_W-1:0]   outWordData;
    logic [CNT_W-1:0]    outWordLanes;
    logic                inWordReady;
    logic [SEL_W-1:0]    outSel;

    modport slave (
        input  inSymValid, inSymData, inFlush, inWordReady,
        output outSymReady, outWordValid, outWordData, outWordLanes, outSel
    );

    modport master (
        output inSymValid, inSymData, inFlush, inWordReady,
        input  outSymReady, outWordValid, outWordData, outWordLanes, outSel
    );

endinterface

// File: rtl/demux_sym_packer_demux.sv
// 4-bit 1:4 demux: routes inData onto lane inSel of a 16-bit bus, other lanes zero.
module DEMUX144
    import zigbee_pkg::*;
(
    input  logic [SYM_W-1:0]  inData,
    input  logic [SEL_W-1:0]  inSel,
    output logic [WORD_W-1:0] outData
);

    always_comb begin
        outData = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (inSel == SEL_W'(k)) begin
                outData[WORD_W-1-SYM_W*k -: SYM_W] = inData;
            end
        end
    end

endmodule

// File: rtl/demux_sym_packer.sv
// Packs a stream of 4-bit symbols into 16-bit words through a round-robin demux,
// with a one-word output slot so intake keeps going while a word waits downstream.
module demux_sym_packer
    import zigbee_pkg::*;
#(
    parameter logic [SYM_W-1:0] PAD_NIBBLE = 4'h0
) (
    input  logic               clk,
    input  logic               resetn,
    demux_sym_packer_if.slave  bus
);

    localparam logic [WORD_W-1:0] PAD_WORD = {NUM_LANES{PAD_NIBBLE}};

    packer_state_t     state;
    packer_state_t     stateNext;

    logic [WORD_W-1:0] acc;
    logic [SEL_W-1:0]  sel;
    logic [CNT_W-1:0]  count;

    logic              wordValid;
    logic [WORD_W-1:0] wordData;
    logic [CNT_W-1:0]  wordLanes;

    logic [WORD_W-1:0] routed;
    logic [WORD_W-1:0] accWritten;
    logic [CNT_W-1:0]  countWritten;
    logic              accept;
    logic              slotFree;
    logic              closeEv;
    logic              transfer;

    DEMUX144 u_demux (
        .inData  (bus.inSymData),
        .inSel   (sel),
        .outData (routed)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= FILL;
        end else begin
            state <= stateNext;
        end
    end

    // accWritten/countWritten describe the word including a same-cycle symbol,
    // so a flush or lane-3 accept closes the word with that symbol already in it.
    always_comb begin
        stateNext    = state;
        accept       = bus.inSymValid && (state == FILL);
        slotFree     = !wordValid || bus.inWordReady;
        accWritten   = accept ? ((acc & ~lane_mask(sel)) | routed) : acc;
        countWritten = count + CNT_W'(accept);
        closeEv      = (state == FILL) &&
                       ((accept && (sel == SEL_W'(NUM_LANES - 1))) ||
                        (bus.inFlush && (countWritten != '0)));
        transfer     = (closeEv || (state == HOLD)) && slotFree;

        unique case (state)
            FILL: if (closeEv && !slotFree) stateNext = HOLD;
            HOLD: if (slotFree)             stateNext = FILL;
            default: stateNext = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc   <= PAD_WORD;
            sel   <= '0;
            count <= '0;
        end else if (transfer) begin
            acc   <= PAD_WORD;
            sel   <= '0;
            count <= '0;
        end else if (accept) begin
            acc   <= accWritten;
            sel   <= sel + SEL_W'(1);
            count <= countWritten;
        end
    end

    // Data and lane count are left untouched when a word is consumed; only valid drops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wordValid <= 1'b0;
            wordData  <= '0;
            wordLanes <= '0;
        end else if (transfer) begin
            wordValid <= 1'b1;
            wordData  <= accWritten;
            wordLanes <= countWritten;
        end else if (bus.inWordReady) begin
            wordValid <= 1'b0;
        end
    end

    assign bus.outSymReady  = (state == FILL);
    assign bus.outWordValid = wordValid;
    assign bus.outWordData  = wordData;
    assign bus.outWordLanes = wordLanes;
    assign bus.outSel       = sel;

endmodule
